// File: rtl/mover_2d_burst_gen.sv
// mover_2d_burst_gen: walks a height x width-byte region with a row stride and emits AXI4 burst commands split at MAX_BURST beats and 4KB boundaries.
//  ACLK/ARESETn           clock, synchronous active-low reset
//  cfg_go/base/width/height/stride  start pulse and transfer geometry, sampled on go
//  cfg_busy/done/err      transfer in progress, end-of-transfer pulse, illegal-config pulse
//  cmd_valid/ready        burst command handshake
//  cmd_addr/len/last      burst start address, AXI4 LEN (beats-1), last burst of transfer
module mover_2d_burst_gen #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int MAX_BURST    = 16,
  parameter int WIDTH_CNT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cfg_go,
  input  logic [AXI_WIDTH_AD-1:0] cfg_base,
  input  logic [WIDTH_CNT-1:0]    cfg_width,
  input  logic [WIDTH_CNT-1:0]    cfg_height,
  input  logic [AXI_WIDTH_AD-1:0] cfg_stride,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [AXI_WIDTH_AD-1:0] cmd_addr,
  output logic [7:0]              cmd_len,
  output logic                    cmd_last
);
  localparam int BYTES = AXI_WIDTH_DA / 8;
  localparam int SH    = $clog2(BYTES);
  typedef enum logic [2:0] {IDLE, CHECK, CALC, ISSUE, DONE} state_t;
  state_t state_q, state_d;
  logic [AXI_WIDTH_AD-1:0] addr_q, addr_d, row_start_q, row_start_d, stride_q, stride_d;
  logic [WIDTH_CNT-1:0]    width_q, width_d, rows_left_q, rows_left_d, row_beats_q, row_beats_d;
  logic [8:0]              len_q, len_d, len_calc;
  logic                    last_q, last_d, err_q, err_d, illegal, row_end;
  logic [31:0]             row_beats32, bound_beats, min_a;
  logic [AXI_WIDTH_AD-1:0] next_row, step;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      row_start_q <= '0;
      stride_q    <= '0;
      width_q     <= '0;
      rows_left_q <= '0;
      row_beats_q <= '0;
      len_q       <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_start_q <= row_start_d;
      stride_q    <= stride_d;
      width_q     <= width_d;
      rows_left_q <= rows_left_d;
      row_beats_q <= row_beats_d;
      len_q       <= len_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    illegal     = width_q == '0 || rows_left_q == '0 ||
                  (addr_q & AXI_WIDTH_AD'(BYTES - 1)) != '0 || (width_q & WIDTH_CNT'(BYTES - 1)) != '0;
    row_beats32 = 32'(row_beats_q);
    bound_beats = 32'((13'h1000 - {1'b0, addr_q[11:0]}) >> SH);
    min_a       = row_beats32 < bound_beats ? row_beats32 : bound_beats;
    len_calc    = min_a < 32'(MAX_BURST) ? min_a[8:0] : 9'(MAX_BURST);
    row_end     = row_beats_q == WIDTH_CNT'(len_q);
    step        = AXI_WIDTH_AD'(len_q) << SH;
    next_row    = row_start_q + stride_q;
    state_d     = state_q;
    addr_d      = addr_q;
    row_start_d = row_start_q;
    stride_d    = stride_q;
    width_d     = width_q;
    rows_left_d = rows_left_q;
    row_beats_d = row_beats_q;
    len_d       = len_q;
    last_d      = last_q;
    err_d       = err_q;
    case (state_q)
      IDLE: if (cfg_go) begin
        state_d     = CHECK;
        addr_d      = cfg_base;
        row_start_d = cfg_base;
        stride_d    = cfg_stride;
        width_d     = cfg_width;
        rows_left_d = cfg_height;
        row_beats_d = cfg_width >> SH;
        err_d       = 1'b0;
      end
      CHECK: begin
        err_d   = illegal;
        state_d = illegal ? DONE : CALC;
      end
      CALC: begin
        len_d   = len_calc;
        last_d  = rows_left_q == WIDTH_CNT'(1) && row_beats32 == 32'(len_calc);
        state_d = ISSUE;
      end
      ISSUE: if (cmd_ready) begin
        if (row_end) begin
          row_start_d = next_row;
          addr_d      = next_row;
          row_beats_d = width_q >> SH;
          rows_left_d = rows_left_q - WIDTH_CNT'(1);
          state_d     = rows_left_q == WIDTH_CNT'(1) ? DONE : CALC;
        end else begin
          addr_d      = addr_q + step;
          row_beats_d = row_beats_q - WIDTH_CNT'(len_q);
          state_d     = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = state_q == ISSUE;
    cmd_addr  = cmd_valid ? addr_q : '0;
    cmd_len   = cmd_valid ? 8'(len_q - 9'd1) : 8'd0;
    cmd_last  = cmd_valid && last_q;
    cfg_busy  = state_q != IDLE;
    cfg_done  = state_q == DONE;
    cfg_err   = cfg_done && err_q;
  end
endmodule
